tick_irq_gen: RTL and testbench

TICK_IRQ_GEN -- requirements
Module: tick_irq_gen

---
 rtl/tick_irq_gen.sv | 113 +++++++++++
 tb/tb_tick_irq_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_irq_gen.sv
// tick_irq_gen: N_CH independent periodic interrupt channels.
// Each channel divides clk by (div+1) and raises a pending flag on every
// period wrap. The pending flags are ORed into one interrupt request, and
// irq_id reports the lowest-numbered pending channel.
// Optional feature: define TICK_IRQ_OVR_EN to build the sticky per-channel
// overrun flags. Without it, ovr is tied to zero and no overrun flops exist.
module tick_irq_gen #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 16,
  parameter int DIV_RESET = 6249,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_we,
  input  logic [CH_W-1:0]  div_ch,
  input  logic [CNT_W-1:0] div_data,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  mask,
  input  logic [N_CH-1:0]  ack,
  output logic [N_CH-1:0]  pend,
  output logic [N_CH-1:0]  ovr,
  output logic             ei_req,
  output logic [CH_W-1:0]  irq_id
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] div_reg;
      logic             pend_reg;
      logic             wr_hit;
      logic             at_end;
      logic             tick;

      // A write whose channel index is out of range matches no channel,
      // so it is silently dropped.
      assign wr_hit = div_we && (int'(div_ch) == gi);
      assign at_end = (cnt_reg == div_reg);
      // A divisor write restarts the period, so it also swallows a tick
      // that would otherwise land on the same edge.
      assign tick   = en[gi] && at_end && !wr_hit;

      // Period counter and divisor register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
          div_reg <= DIV_INIT;
        end else if (wr_hit) begin
          cnt_reg <= '0;
          div_reg <= div_data;
        end else if (!en[gi] || at_end) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      // Pending flag: mask clears, tick sets (beats ack), ack clears.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pend_reg <= 1'b0;
        end else if (mask[gi]) begin
          pend_reg <= 1'b0;
        end else if (tick) begin
          pend_reg <= 1'b1;
        end else if (ack[gi]) begin
          pend_reg <= 1'b0;
        end
      end

      assign pend[gi] = pend_reg;

`ifdef TICK_IRQ_OVR_EN
      logic ovr_reg;

      // Sticky overrun: a tick arriving while the previous one is still
      // unserviced. Ack or mask always clears, even against a new tick.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovr_reg <= 1'b0;
        end else if (ack[gi] || mask[gi]) begin
          ovr_reg <= 1'b0;
        end else if (tick && pend_reg) begin
          ovr_reg <= 1'b1;
        end
      end

      assign ovr[gi] = ovr_reg;
`endif
    end
  endgenerate

`ifndef TICK_IRQ_OVR_EN
  assign ovr = '0;
`endif

  assign ei_req = |pend;

  // Lowest-numbered pending channel wins; zero when nothing is pending.
  always_comb begin
    irq_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        irq_id = CH_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_tick_irq_gen.sv
// Directed testbench for tick_irq_gen with N_CH=2 and default parameters.
// Expected output states are queued as each stimulus step is driven and
// compared once the clock edge has produced the DUT response.
module tb_tick_irq_gen;

  localparam int N_CH  = 2;
  localparam int CNT_W = 16;
  localparam int CH_W  = 1;
  localparam int FIRST_TICK = 6250;

`ifdef TICK_IRQ_OVR_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             div_we;
  logic [CH_W-1:0]  div_ch;
  logic [CNT_W-1:0] div_data;
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  mask;
  logic [N_CH-1:0]  ack;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  ovr;
  logic             ei_req;
  logic [CH_W-1:0]  irq_id;

  typedef struct {
    string      tag;
    logic [1:0] pend;
    logic [1:0] ovr;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  tick_irq_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_RESET(6249)) dut (
    .clk      (clk),
    .reset    (reset),
    .div_we   (div_we),
    .div_ch   (div_ch),
    .div_data (div_data),
    .en       (en),
    .mask     (mask),
    .ack      (ack),
    .pend     (pend),
    .ovr      (ovr),
    .ei_req   (ei_req),
    .irq_id   (irq_id)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [1:0] ep, input logic [1:0] eo);
    exp_t e;
    e.tag  = tag;
    e.pend = ep;
    e.ovr  = eo;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare all four outputs against it.
  task automatic check_pop();
    exp_t       e;
    logic       e_req;
    logic [0:0] e_id;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: observed no entry required one");
      return;
    end
    e     = exp_q.pop_front();
    e_req = |e.pend;
    e_id  = (!e.pend[0] && e.pend[1]) ? 1'b1 : 1'b0;
    $display("[%0t] %s pend=%b ovr=%b ei_req=%b irq_id=%0d", $time, e.tag, pend, ovr, ei_req, irq_id);
    n_cmp++;
    assert (pend === e.pend) else begin
      n_fail++;
      $error("FAIL %s pend: observed %b expected %b", e.tag, pend, e.pend);
    end
    n_cmp++;
    assert (ovr === e.ovr) else begin
      n_fail++;
      $error("FAIL %s ovr: observed %b expected %b", e.tag, ovr, e.ovr);
    end
    n_cmp++;
    assert (ei_req === e_req) else begin
      n_fail++;
      $error("FAIL %s ei_req: observed %b expected %b", e.tag, ei_req, e_req);
    end
    n_cmp++;
    assert (irq_id === e_id) else begin
      n_fail++;
      $error("FAIL %s irq_id: observed %0d expected %0d", e.tag, irq_id, e_id);
    end
  endtask

  // Apply ack for one clock edge along with whatever else the caller set up,
  // then check the state produced by that edge.
  task automatic cyc(input logic [1:0] a, input logic [1:0] ep, input logic [1:0] eo, input string tag);
    ack = a;
    push_exp(tag, ep, eo);
    @(posedge clk);
    #1;
    ack    = '0;
    div_we = 1'b0;
    check_pop();
  endtask

  // Check the current output state without advancing the clock.
  task automatic check_now(input logic [1:0] ep, input logic [1:0] eo, input string tag);
    push_exp(tag, ep, eo);
    check_pop();
  endtask

  // Count edges from reset release until ch0 pends; ch1 must stay idle.
  task automatic wait_pend0(input string tag);
    int n;
    int exp_lat;
    bit got;
    bit seen1;
    n     = 0;
    got   = 1'b0;
    seen1 = 1'b0;
    while (!got && n < FIRST_TICK + 500) begin
      @(posedge clk);
      #1;
      n++;
      if (pend[1]) seen1 = 1'b1;
      if (pend[0]) got = 1'b1;
    end
    exp_lat = lat_q.pop_front();
    $display("[%0t] %s first ch0 pend after %0d cycles (got=%0b)", $time, tag, n, got);
    n_cmp++;
    assert (got && n == exp_lat) else begin
      n_fail++;
      $error("FAIL %s latency: observed %0d (seen=%0b) expected %0d", tag, n, got, exp_lat);
    end
    n_cmp++;
    assert (seen1 == 1'b0) else begin
      n_fail++;
      $error("FAIL %s ch1_idle: observed pend[1] seen=%0b expected 0", tag, seen1);
    end
  endtask

  initial begin
    reset    = 1'b1;
    div_we   = 1'b0;
    div_ch   = '0;
    div_data = '0;
    en       = 2'b00;
    mask     = 2'b00;
    ack      = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_now(2'b00, 2'b00, "reset_state");

    // Default divisor, ch0 only.
    en    = 2'b01;
    reset = 1'b0;
    lat_q.push_back(FIRST_TICK);
    wait_pend0("t1_default");
    check_now(2'b01, 2'b00, "t1_pend0");

    en = 2'b00;
    cyc(2'b11, 2'b00, 2'b00, "t1_clear");

    // ch1 period 4 via divisor write; write edge itself is cycle 0.
    en       = 2'b10;
    div_we   = 1'b1;
    div_ch   = 1'b1;
    div_data = 16'd3;
    cyc(2'b00, 2'b00, 2'b00, "t2_write");
    for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00, 2'b00, "t2_count");
    cyc(2'b00, 2'b10, 2'b00, "t2_tick1");
    cyc(2'b10, 2'b00, 2'b00, "t2_ack");
    cyc(2'b00, 2'b00, 2'b00, "t2_idle");
    cyc(2'b00, 2'b00, 2'b00, "t2_idle");
    cyc(2'b00, 2'b10, 2'b00, "t2_tick2");

    // Leave the tick unserviced across two more periods.
    for (int i = 0; i < 3; i++) cyc(2'b00, 2'b10, 2'b00, "t3_wait");
    cyc(2'b00, 2'b10, {OVR, 1'b0}, "t3_overrun");
    for (int i = 0; i < 7; i++) cyc(2'b00, 2'b10, {OVR, 1'b0}, "t3_sticky");
    cyc(2'b10, 2'b10, 2'b00, "t3_ack_on_tick");

    // Both channels with div=1, started together.
    en = 2'b00;
    cyc(2'b11, 2'b00, 2'b00, "t4_clear");
    div_we   = 1'b1;
    div_ch   = 1'b0;
    div_data = 16'd1;
    cyc(2'b00, 2'b00, 2'b00, "t4_wr_ch0");
    div_we   = 1'b1;
    div_ch   = 1'b1;
    div_data = 16'd1;
    cyc(2'b00, 2'b00, 2'b00, "t4_wr_ch1");
    en = 2'b11;
    cyc(2'b00, 2'b00, 2'b00, "t4_start");
    cyc(2'b00, 2'b11, 2'b00, "t4_both");
    cyc(2'b01, 2'b10, 2'b00, "t4_ack0");
    cyc(2'b00, 2'b11, {OVR, 1'b0}, "t4_again");

    // Mask ch0 across two of its ticks, then unmask.
    en   = 2'b01;
    mask = 2'b01;
    cyc(2'b10, 2'b00, 2'b00, "t5_mask_on");
    for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00, 2'b00, "t5_masked");
    mask = 2'b00;
    cyc(2'b00, 2'b00, 2'b00, "t5_unmask");
    cyc(2'b00, 2'b01, 2'b00, "t5_tick");

    // Reset in the middle of a long ch0 period while ch1 is overrunning.
    en       = 2'b11;
    div_we   = 1'b1;
    div_ch   = 1'b0;
    div_data = 16'd200;
    cyc(2'b00, 2'b01, 2'b00, "t6_write");
    repeat (99) @(posedge clk);
    #1;
    check_now(2'b11, {OVR, 1'b0}, "t6_before_reset");
    #2;
    reset = 1'b1;
    en    = 2'b01;
    #1;
    check_now(2'b00, 2'b00, "t6_async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    lat_q.push_back(FIRST_TICK);
    wait_pend0("t6_after_reset");

    // div=0 on ch1: tick every enabled cycle, ack cannot beat a tick,
    // and a divisor write suppresses the coincident tick.
    en       = 2'b10;
    div_we   = 1'b1;
    div_ch   = 1'b1;
    div_data = 16'd0;
    cyc(2'b01, 2'b00, 2'b00, "t7_write");
    cyc(2'b00, 2'b10, 2'b00, "t7_tick");
    cyc(2'b10, 2'b10, 2'b00, "t7_ack_vs_tick");
    cyc(2'b00, 2'b10, {OVR, 1'b0}, "t7_overrun");
    div_we   = 1'b1;
    div_ch   = 1'b1;
    div_data = 16'd0;
    cyc(2'b10, 2'b00, 2'b00, "t7_write_supp");
    cyc(2'b00, 2'b10, 2'b00, "t7_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
